// File: rtl/vram_rect_fill_if.sv
// Bus-side signals of the rectangle fill engine: CPU register port, VRAM write port and status.
interface vram_rect_fill_if #(
  parameter int ADDR_W = 15
);
  logic              reg_we;
  logic [1:0]        reg_addr;
  logic [31:0]       reg_data_in;
  logic              cpu_vram_req;
  logic [ADDR_W-1:0] vram_waddr;
  logic [7:0]        vram_data_in;
  logic              data_vram_we;
  logic              busy;
  logic              done;
  logic [31:0]       status;

  modport master (
    output reg_we, reg_addr, reg_data_in, cpu_vram_req,
    input  vram_waddr, vram_data_in, data_vram_we, busy, done, status
  );

  modport slave (
    input  reg_we, reg_addr, reg_data_in, cpu_vram_req,
    output vram_waddr, vram_data_in, data_vram_we, busy, done, status
  );
endinterface

// File: rtl/vram_rect_fill.sv
// Clipped rectangle fill engine: writes one pixel per clock in row-major order,
// yielding the VRAM write port to the CPU whenever it asks for it.
module vram_rect_fill #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic            clk,
  input  logic            rst,
  vram_rect_fill_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        x0_q, x0_d, w_q, w_d, color_q, color_d, x_q, x_d;
  logic [6:0]        y0_q, y0_d, h_q, h_d, y_q, y_d;
  logic [8:0]        x_end_q, x_end_d;
  logic [7:0]        y_end_q, y_end_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, waddr_q, waddr_d;
  logic [7:0]        data_q, data_d;
  logic [15:0]       pix_q, pix_d;

  logic              wr_origin, wr_size, wr_color, wr_ctrl, start, abort;
  logic [8:0]        x_sum, x_clip;
  logic [7:0]        y_sum, y_clip;
  logic              empty, in_fill, writing, col_last, row_last;
  logic [ADDR_W-1:0] fill_addr;
  logic [16:0]       unused_data_bits;

  assign wr_origin = bus.reg_we && (bus.reg_addr == 2'd0);
  assign wr_size   = bus.reg_we && (bus.reg_addr == 2'd1);
  assign wr_color  = bus.reg_we && (bus.reg_addr == 2'd2);
  assign wr_ctrl   = bus.reg_we && (bus.reg_addr == 2'd3);
  assign start     = wr_ctrl && bus.reg_data_in[0];
  assign abort     = wr_ctrl && bus.reg_data_in[1];
  assign unused_data_bits = {bus.reg_data_in[31:23], bus.reg_data_in[15:8]};

  // Sums carry one extra bit so an oversized rectangle clips instead of wrapping.
  assign x_sum  = {1'b0, x0_q} + {1'b0, w_q};
  assign y_sum  = {1'b0, y0_q} + {1'b0, h_q};
  assign x_clip = (x_sum > 9'(H_RES)) ? 9'(H_RES) : x_sum;
  assign y_clip = (y_sum > 8'(V_RES)) ? 8'(V_RES) : y_sum;
  assign empty  = (w_q == 8'd0) || (h_q == 7'd0) ||
                  ({1'b0, x0_q} >= 9'(H_RES)) || ({1'b0, y0_q} >= 8'(V_RES));

  assign in_fill   = (state_q == FILL);
  assign writing   = in_fill && !bus.cpu_vram_req;
  assign fill_addr = row_base_q + ADDR_W'(x_q);
  assign col_last  = (({1'b0, x_q} + 9'd1) == x_end_q);
  assign row_last  = (({1'b0, y_q} + 8'd1) == y_end_q);

  assign bus.vram_waddr   = in_fill ? fill_addr : waddr_q;
  assign bus.vram_data_in = in_fill ? color_q : data_q;
  assign bus.data_vram_we = writing;
  assign bus.busy         = in_fill;
  assign bus.done         = (state_q == DONE);
  assign bus.status       = {in_fill, 15'b0, pix_q};

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    pix_d      = pix_q;
    waddr_d    = in_fill ? fill_addr : waddr_q;
    data_d     = in_fill ? color_q : data_q;

    // Geometry and colour are frozen while a fill is running.
    if (!in_fill) begin
      if (wr_origin) begin
        x0_d = bus.reg_data_in[7:0];
        y0_d = bus.reg_data_in[22:16];
      end
      if (wr_size) begin
        w_d = bus.reg_data_in[7:0];
        h_d = bus.reg_data_in[22:16];
      end
      if (wr_color) color_d = bus.reg_data_in[7:0];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          pix_d = 16'd0;
          if (empty) begin
            state_d = DONE;
          end else begin
            state_d    = FILL;
            x_d        = x0_q;
            y_d        = y0_q;
            x_end_d    = x_clip;
            y_end_d    = y_clip;
            row_base_d = ADDR_W'(y0_q) * ADDR_W'(H_RES);
          end
        end
      end
      FILL: begin
        if (writing) begin
          pix_d = (pix_q == 16'hFFFF) ? pix_q : pix_q + 16'd1;
          if (col_last) begin
            x_d        = x0_q;
            y_d        = y_q + 7'd1;
            row_base_d = row_base_q + ADDR_W'(H_RES);
            if (row_last) state_d = DONE;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
        if (abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      pix_q      <= '0;
      waddr_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      pix_q      <= pix_d;
      waddr_q    <= waddr_d;
      data_q     <= data_d;
    end
  end
endmodule
